block_serial_subtractor: RTL

BLOCK_SERIAL_SUBTRACTOR -- requirements
Module: block_serial_subtractor

---
 rtl/block_serial_subtractor_pkg.sv | 16 +
 rtl/block_serial_subtractor_borrow_skip.sv | 27 ++
 rtl/block_serial_subtractor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/block_serial_subtractor_pkg.sv
// Shared definitions for the block-serial subtractor: FSM encoding and
// the parameter sanity check used at elaboration.
package block_serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when an operand of width w splits into whole m-bit blocks.
    function automatic bit width_divisible(input int unsigned w, input int unsigned m);
        return (m != 0) && ((w % m) == 0);
    endfunction

endpackage

// File: rtl/block_serial_subtractor_borrow_skip.sv
// One M-bit subtraction slice: a + ~b + ~borrow, with the borrow bypassed
// straight through when the two operand slices are equal.
module borrow_skip_block
    import block_serial_subtractor_pkg::*;
#(
    parameter int unsigned M = 4
) (
    input  logic [M-1:0] a_blk,
    input  logic [M-1:0] b_blk,
    input  logic         borrow_in,
    output logic [M-1:0] diff_blk,
    output logic         borrow_out,
    output logic         skip
);

    logic [M:0] sum;
    logic       ripple_borrow;

    always_comb begin
        sum           = {1'b0, a_blk} + {1'b0, ~b_blk} + {{M{1'b0}}, ~borrow_in};
        ripple_borrow = ~sum[M];
        skip          = &(a_blk ^ ~b_blk);
        diff_blk      = sum[M-1:0];
        borrow_out    = skip ? borrow_in : ripple_borrow;
    end

endmodule

// File: rtl/block_serial_subtractor.sv
// Serial subtractor processing one M-bit block per cycle, LSB block first,
// with a valid/ready handshake on operands and result.
module block_serial_subtractor
    import block_serial_subtractor_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned M = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            a,
    input  logic [W-1:0]            b,
    input  logic                    bin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            diff,
    output logic                    bout,
    output logic                    ovf,
    output logic [$clog2(W/M):0]    skip_cnt
);

    localparam int unsigned NB = W / M;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CW = $clog2(NB) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    generate
        if (!width_divisible(W, M)) begin : g_param_check
            $error("block_serial_subtractor: W must be a multiple of M");
        end
    endgenerate

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic          borrow_q, borrow_d, bout_q, bout_d, ovf_q, ovf_d;
    logic [CW-1:0] skip_q, skip_d;

    logic [M-1:0]  a_blk, b_blk, diff_blk;
    logic          blk_borrow, blk_skip;

    always_comb begin
        a_blk = a_q[idx_q*M +: M];
        b_blk = b_q[idx_q*M +: M];
    end

    borrow_skip_block #(.M(M)) u_blk (
        .a_blk      (a_blk),
        .b_blk      (b_blk),
        .borrow_in  (borrow_q),
        .diff_blk   (diff_blk),
        .borrow_out (blk_borrow),
        .skip       (blk_skip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        skip_d   = skip_q;
        if (state_q == IDLE && in_valid) begin
            a_d      = a;
            b_d      = b;
            borrow_d = bin;
            idx_d    = '0;
            skip_d   = '0;
        end else if (state_q == RUN) begin
            diff_d[idx_q*M +: M] = diff_blk;
            borrow_d             = blk_borrow;
            skip_d               = skip_q + CW'(blk_skip);
            if (idx_q == LAST_IDX) begin
                // The top block's own diff bit is the sign of the result.
                idx_d  = '0;
                bout_d = blk_borrow;
                ovf_d  = (a_q[W-1] != b_q[W-1]) && (diff_blk[M-1] != a_q[W-1]);
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            skip_q   <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            skip_q   <= skip_d;
        end
    end

    always_comb begin
        diff     = diff_q;
        bout     = bout_q;
        ovf      = ovf_q;
        skip_cnt = skip_q;
    end

endmodule
